instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of the PC address generator.
- Accepts the current PC, issues one request on the instruction-memory bus (req/gnt/rvalid), captures the returned word and presents it to decode with a valid/ready handshake.
- Exposes fetch_ready so the PC register is stalled while a fetch is in flight.
- Supports flush on redirect and reports misaligned-PC and bus-timeout faults.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- DATA_W, 32, instruction width.
- TIMEOUT, 16, max cycles spent in REQ/WAIT/DRAIN before a timeout fault; valid range 2..255.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- pc  input  ADDR_W  PC from address generator.
- pc_valid  input  1  PC stable, fetch requested.
- fetch_ready  output  1  unit idle, will accept pc this cycle; PC register holds while low.
- flush  input  1  redirect; discard in-flight or held instruction.
- imem_req  output  1  memory request.
- imem_addr  output  ADDR_W  request address.
- imem_gnt  input  1  request accepted.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  DATA_W  read data.
- instr  output  DATA_W  fetched instruction.
- instr_pc  output  ADDR_W  PC of instr.
- instr_valid  output  1  instr valid to decode.
- instr_ready  input  1  decode accepts instr.
- fault  output  1  one-cycle fault pulse.
- fault_cause  output  2  01 misaligned, 10 timeout; holds until the next fault.

Behaviour:
- Reset (sync, active-high; applies mid-operation too): state=IDLE; all outputs 0 (instr, instr_pc, imem_addr, fault_cause = 0). A response arriving after reset is ignored.
- State is a 5-state FSM: IDLE, REQ, WAIT, HOLD, DRAIN. All outputs are registered or decoded from state only; there is no combinational path from input to output.
- IDLE:
  - fetch_ready=1.
  - pc_valid & !flush & pc[1:0]!=0: fault pulses next cycle, cause=01, no request, stay IDLE.
  - pc_valid & !flush & aligned: latch pc into addr_q, go REQ.
  - flush in IDLE: pc_valid ignored that cycle.
- REQ:
  - imem_req=1, imem_addr=addr_q.
  - gnt: go WAIT.
  - flush & !gnt: go IDLE; req drops next cycle.
  - flush & gnt: go DRAIN.
- WAIT:
  - rvalid & !flush: instr<=rdata, instr_pc<=addr_q, go HOLD.
  - flush & !rvalid: go DRAIN.
  - flush & rvalid: data discarded, go IDLE.
  - A rvalid received in any state other than WAIT or DRAIN is ignored.
- HOLD:
  - instr_valid=1; instr and instr_pc are stable.
  - instr_ready: go IDLE.
  - flush has priority over instr_ready: go IDLE, no handshake counted.
- DRAIN: await rvalid, discard the data, go IDLE. flush has no further effect.
- Timer:
  - 8-bit counter cleared on entry to REQ, WAIT and DRAIN; increments each cycle in those states.
  - At count==TIMEOUT-1 without the exit event: fault pulse, cause=10, go IDLE.
  - A late rvalid is then ignored in IDLE.
- Latency, zero-wait memory (gnt in the REQ cycle, rvalid the next cycle):
  - pc_valid at cycle 0.
  - imem_req at cycle 1.
  - rvalid at cycle 2.
  - instr_valid at cycle 3.
  - fetch_ready high again the cycle after the instr_ready handshake.
- Addresses are always word-aligned; there is no address arithmetic and no wrap handling needed.

Test Plan:
- Zero-wait fetch: pc=0x00000010, pc_valid=1; memory grants immediately, rvalid next cycle with 0x00500093 -> instr_valid at cycle 3, instr=0x00500093, instr_pc=0x10, fetch_ready=0 during cycles 1-3.
- Back-pressure: instr_ready=0 for 5 cycles -> instr_valid, instr and instr_pc held constant; on ready=1 -> IDLE, fetch_ready=1 next cycle.
- Misaligned: pc=0x00000006 -> imem_req never asserted; fault=1 for exactly one cycle; fault_cause=01.
- Flush in WAIT: gnt given, flush before rvalid -> DRAIN; rvalid with 0xDEADBEEF -> instr_valid stays 0; next pc=0x20 fetches normally.
- Timeout: TIMEOUT=16, gnt held 0 -> imem_req high for 16 cycles, then fault pulse, cause=10, imem_req=0, fetch_ready=1.
- Reset mid-fetch: rst asserted in WAIT -> next cycle all outputs 0; a subsequent rvalid produces no instr_valid.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: takes one PC from the address generator, issues a
// single req/gnt/rvalid transaction to instruction memory and hands the
// returned word to decode through a valid/ready handshake. Supports redirect
// flush, a misaligned-PC fault and a per-phase bus timeout fault.
module instr_fetch_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_valid,
  output logic              fetch_ready,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              fault,
  output logic [1:0]        fault_cause
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  // Last timer value a bus phase may reach before it is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [7:0]        timer_q, timer_d;
  logic              fault_q, fault_d;
  logic [1:0]        cause_q, cause_d;
  logic              timer_expired;
  logic              next_timed;

  assign timer_expired = (timer_q == TMO_LAST);

  // Handshake outputs are decoded from the state register only, so no input
  // can reach an output combinationally.
  assign fetch_ready = (state_q == S_IDLE);
  assign imem_req    = (state_q == S_REQ);
  assign instr_valid = (state_q == S_HOLD);
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;

  // Next-state, capture and fault decisions for the fetch FSM.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    fault_d    = 1'b0;
    cause_d    = cause_q;

    case (state_q)
      S_IDLE: begin
        // A flush in IDLE suppresses the PC for that cycle entirely.
        if (pc_valid && !flush) begin
          if (pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            cause_d = CAUSE_MISALIGN;
          end else begin
            addr_d  = pc;
            state_d = S_REQ;
          end
        end
      end

      S_REQ: begin
        // Once granted, the response must still be consumed even if flushed.
        if (imem_gnt) begin
          state_d = flush ? S_DRAIN : S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end else if (timer_expired) begin
          fault_d = 1'b1;
          cause_d = CAUSE_TIMEOUT;
          state_d = S_IDLE;
        end
      end

      S_WAIT: begin
        if (imem_rvalid) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = addr_q;
            state_d    = S_HOLD;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end else if (timer_expired) begin
          fault_d = 1'b1;
          cause_d = CAUSE_TIMEOUT;
          state_d = S_IDLE;
        end
      end

      S_HOLD: begin
        // Flush and handshake both return to IDLE; flush simply wins the
        // tie, and the held word is dropped.
        if (flush || instr_ready) begin
          state_d = S_IDLE;
        end
      end

      S_DRAIN: begin
        if (imem_rvalid) begin
          state_d = S_IDLE;
        end else if (timer_expired) begin
          fault_d = 1'b1;
          cause_d = CAUSE_TIMEOUT;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Phase timer: restarts on every entry to a bus phase, counts while in it.
  always_comb begin
    next_timed = (state_d == S_REQ) || (state_d == S_WAIT) || (state_d == S_DRAIN);
    timer_d    = 8'd0;
    if (next_timed && (state_d == state_q)) begin
      timer_d = timer_q + 8'd1;
    end
  end

  // All state, including the registered datapath outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      timer_q    <= 8'd0;
      fault_q    <= 1'b0;
      cause_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      timer_q    <= timer_d;
      fault_q    <= fault_d;
      cause_q    <= cause_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a table of single-fetch scenarios,
// hand-written flush/reset/timeout sequences, and a randomized run checked
// against a transaction-level model (queue of expected PCs plus a memory
// content function).
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_valid;
  logic        fetch_ready;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        fault;
  logic [1:0]  fault_cause;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] last_cause;

  instr_fetch_unit #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .fetch_ready(fetch_ready),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .fault      (fault),
    .fault_cause(fault_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          gnt_dly;
    int          rv_dly;
    int          rdy_dly;
    logic [31:0] rdata;
    logic        exp_fault;
    logic [1:0]  exp_cause;
    int          exp_cycle;
    int          exp_req;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[10];

  // Memory contents seen by the random run.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    pc_valid    = 1'b0;
    flush       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
  endtask

  task automatic start_fetch(input logic [31:0] a);
    pc       = a;
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
  endtask

  // Applies one table row from IDLE and follows it until the unit is idle again.
  task automatic run_vec(input vec_t v, input int idx);
    int cyc = 0;
    int req_n = 0;
    int wait_n = 0;
    int hold_n = 0;
    int first_evt = -1;
    bit in_wait = 0;
    bit got_valid = 0;
    bit got_fault = 0;
    bit handshake = 0;
    bit done = 0;
    pc       = v.pc;
    pc_valid = 1'b1;
    while (!done && cyc < 80) begin
      tick();
      cyc++;
      clear_inputs();
      if (fault) begin
        if (!got_fault && first_evt < 0) first_evt = cyc;
        got_fault = 1;
        in_wait   = 0;
      end
      if (instr_valid) begin
        if (!got_valid && first_evt < 0) first_evt = cyc;
        got_valid = 1;
        check($sformatf("v%0d_hold_instr", idx), instr, v.exp_instr);
        check($sformatf("v%0d_hold_pc", idx), instr_pc, v.exp_pc);
        if (hold_n == v.rdy_dly) begin
          instr_ready = 1'b1;
          handshake   = 1;
        end
        hold_n++;
      end else if ((handshake || got_fault) && fetch_ready) begin
        done = 1;
      end
      if (!done) begin
        check($sformatf("v%0d_busy_fetch_ready", idx), fetch_ready, 0);
        if (imem_req) begin
          check($sformatf("v%0d_imem_addr", idx), imem_addr, v.pc);
          if (req_n == v.gnt_dly) begin
            imem_gnt = 1'b1;
            in_wait  = 1;
          end
          req_n++;
        end else if (in_wait && !instr_valid) begin
          if (wait_n == v.rv_dly) begin
            imem_rvalid = 1'b1;
            imem_rdata  = v.rdata;
            in_wait     = 0;
          end
          wait_n++;
        end
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL v%0d_bound: got no completion within 80 cycles required completion", idx);
    end
    check($sformatf("v%0d_event_cycle", idx), first_evt, v.exp_cycle);
    check($sformatf("v%0d_fault_seen", idx), got_fault, v.exp_fault);
    check($sformatf("v%0d_valid_seen", idx), got_valid, !v.exp_fault);
    check($sformatf("v%0d_req_cycles", idx), req_n, v.exp_req);
    if (v.exp_fault) last_cause = v.exp_cause;
    tick();
    check($sformatf("v%0d_fault_pulse_end", idx), fault, 0);
    check($sformatf("v%0d_cause_held", idx), fault_cause, last_cause);
    check($sformatf("v%0d_idle_ready", idx), fetch_ready, 1);
    $display("vec %0d pc=%h event_cycle=%0d req_cycles=%0d fault=%0d", idx, v.pc, first_evt, req_n, got_fault);
  endtask

  initial begin
    logic [31:0] exp_pc_q[$];
    vec_t        after_flush;
    bit          fault_exp;
    bit          fault_exp_next;
    bit          mem_wait;
    int          gnt_dly;
    int          rv_dly;
    int          n_done;
    logic [31:0] mem_addr;
    logic [31:0] rnd;
    logic [31:0] exp_a;

    //             pc            g   r   rdy rdata          flt   cause  cyc req instr          pc
    vecs[0] = '{32'h00000010,  0,  0,  0, 32'h00500093, 1'b0, 2'b00,  3,  1, 32'h00500093, 32'h00000010};
    vecs[1] = '{32'h00000014,  0,  0,  5, 32'h00A00113, 1'b0, 2'b00,  3,  1, 32'h00A00113, 32'h00000014};
    vecs[2] = '{32'h00000020,  3,  2,  1, 32'h12345678, 1'b0, 2'b00,  8,  4, 32'h12345678, 32'h00000020};
    vecs[3] = '{32'h00000006,  0,  0,  0, 32'h0,        1'b1, 2'b01,  1,  0, 32'h0,        32'h0};
    vecs[4] = '{32'h00000101,  0,  0,  0, 32'h0,        1'b1, 2'b01,  1,  0, 32'h0,        32'h0};
    vecs[5] = '{32'h00000040, 15,  0,  0, 32'hA1B2C3D4, 1'b0, 2'b00, 18, 16, 32'hA1B2C3D4, 32'h00000040};
    vecs[6] = '{32'h00000044, 99,  0,  0, 32'h0,        1'b1, 2'b10, 17, 16, 32'h0,        32'h0};
    vecs[7] = '{32'h00000048,  0, 15,  0, 32'h0badf00d, 1'b0, 2'b00, 18,  1, 32'h0badf00d, 32'h00000048};
    vecs[8] = '{32'h0000004C,  0, 99,  0, 32'h0,        1'b1, 2'b10, 18,  1, 32'h0,        32'h0};
    vecs[9] = '{32'hFFFFFFFC,  1,  1,  2, 32'hCAFEF00D, 1'b0, 2'b00,  5,  2, 32'hCAFEF00D, 32'hFFFFFFFC};
    after_flush = '{32'h00000020, 0, 0, 0, 32'h00100073, 1'b0, 2'b00, 3, 1, 32'h00100073, 32'h00000020};

    // Reset state.
    pc = '0;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    check("rst_fetch_ready", fetch_ready, 1);
    check("rst_imem_req", imem_req, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_fault", fault, 0);
    check("rst_fault_cause", fault_cause, 0);
    rst = 1'b0;
    last_cause = 2'b00;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], i);
    end

    // Flush in WAIT, response drained, then a normal fetch.
    start_fetch(32'h30);
    check("fw_req", imem_req, 1);
    imem_gnt = 1'b1;
    tick();
    clear_inputs();
    flush = 1'b1;
    tick();
    clear_inputs();
    check("fw_drain_busy", fetch_ready, 0);
    check("fw_drain_noreq", imem_req, 0);
    check("fw_drain_novalid", instr_valid, 0);
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEADBEEF;
    check("fw_still_drain", fetch_ready, 0);
    tick();
    clear_inputs();
    check("fw_idle", fetch_ready, 1);
    check("fw_novalid", instr_valid, 0);
    tick();
    check("fw_novalid2", instr_valid, 0);
    $display("seq flush_in_wait done");
    run_vec(after_flush, 10);

    // Flush in REQ without grant returns straight to IDLE.
    start_fetch(32'h50);
    flush = 1'b1;
    tick();
    clear_inputs();
    check("fr_noreq", imem_req, 0);
    check("fr_idle", fetch_ready, 1);
    $display("seq flush_in_req done");

    // Flush together with grant must drain the response.
    start_fetch(32'h54);
    flush    = 1'b1;
    imem_gnt = 1'b1;
    tick();
    clear_inputs();
    check("fg_drain_busy", fetch_ready, 0);
    check("fg_drain_noreq", imem_req, 0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h11111111;
    tick();
    clear_inputs();
    check("fg_idle", fetch_ready, 1);
    check("fg_novalid", instr_valid, 0);
    $display("seq flush_with_gnt done");

    // Flush coinciding with rvalid in WAIT drops the data, no DRAIN.
    start_fetch(32'h58);
    imem_gnt = 1'b1;
    tick();
    clear_inputs();
    flush       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h22222222;
    tick();
    clear_inputs();
    check("frv_idle", fetch_ready, 1);
    check("frv_novalid", instr_valid, 0);
    $display("seq flush_with_rvalid done");

    // Flush in HOLD beats instr_ready.
    start_fetch(32'h5C);
    imem_gnt = 1'b1;
    tick();
    clear_inputs();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h33333333;
    tick();
    clear_inputs();
    check("fh_valid", instr_valid, 1);
    check("fh_instr", instr, 32'h33333333);
    check("fh_pc", instr_pc, 32'h5C);
    flush       = 1'b1;
    instr_ready = 1'b1;
    tick();
    clear_inputs();
    check("fh_dropped", instr_valid, 0);
    check("fh_idle", fetch_ready, 1);
    $display("seq flush_in_hold done");

    // Flush in IDLE hides pc_valid, aligned or not.
    pc       = 32'h60;
    pc_valid = 1'b1;
    flush    = 1'b1;
    tick();
    clear_inputs();
    check("fi_noreq", imem_req, 0);
    check("fi_idle", fetch_ready, 1);
    pc       = 32'h62;
    pc_valid = 1'b1;
    flush    = 1'b1;
    tick();
    clear_inputs();
    check("fi_nofault", fault, 0);
    check("fi_cause_held", fault_cause, last_cause);
    $display("seq flush_in_idle done");

    // DRAIN timeout, then a late rvalid is ignored in IDLE.
    start_fetch(32'h64);
    imem_gnt = 1'b1;
    tick();
    clear_inputs();
    flush = 1'b1;
    tick();
    clear_inputs();
    for (int i = 0; i < 15; i++) begin
      tick();
      check("dt_no_early_fault", fault, 0);
    end
    tick();
    check("dt_fault", fault, 1);
    check("dt_cause", fault_cause, 2'b10);
    check("dt_idle", fetch_ready, 1);
    last_cause = 2'b10;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h44444444;
    tick();
    clear_inputs();
    check("dt_late_novalid", instr_valid, 0);
    check("dt_late_nofault", fault, 0);
    check("dt_late_idle", fetch_ready, 1);
    $display("seq drain_timeout done");

    // Reset asserted in WAIT.
    start_fetch(32'h70);
    imem_gnt = 1'b1;
    tick();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_req", imem_req, 0);
    check("mr_addr", imem_addr, 0);
    check("mr_instr", instr, 0);
    check("mr_instr_pc", instr_pc, 0);
    check("mr_valid", instr_valid, 0);
    check("mr_fault", fault, 0);
    check("mr_cause", fault_cause, 0);
    check("mr_ready", fetch_ready, 1);
    last_cause = 2'b00;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h55555555;
    tick();
    clear_inputs();
    check("mr_late_novalid", instr_valid, 0);
    tick();
    check("mr_late_novalid2", instr_valid, 0);
    $display("seq reset_mid_fetch done");

    // Randomized run against the transaction-level model.
    fault_exp = 0;
    mem_wait  = 0;
    gnt_dly   = $urandom_range(0, 4);
    rv_dly    = 0;
    n_done    = 0;
    mem_addr  = '0;
    for (int c = 0; c < 2540; c++) begin
      check("rnd_fault", fault, fault_exp);
      if (fault) check("rnd_cause", fault_cause, 2'b01);
      if (imem_req) begin
        exp_a = (exp_pc_q.size() > 0) ? exp_pc_q[0] : 32'hFFFFFFFF;
        check("rnd_imem_addr", imem_addr, exp_a);
      end
      clear_inputs();
      fault_exp_next = 0;

      if (c < 2500) begin
        rnd = $urandom;
        if (fetch_ready && ($urandom_range(0, 2) != 0)) begin
          if ($urandom_range(0, 3) == 0) begin
            rnd[1:0] = 2'(($urandom_range(1, 3)));
            fault_exp_next = 1;
          end else begin
            rnd[1:0] = 2'b00;
            exp_pc_q.push_back(rnd);
          end
          pc       = rnd;
          pc_valid = 1'b1;
        end else if (!fetch_ready && ($urandom_range(0, 3) == 0)) begin
          pc       = rnd;
          pc_valid = 1'b1;
        end
      end

      if (imem_req && !mem_wait) begin
        if (gnt_dly == 0) begin
          imem_gnt = 1'b1;
          mem_wait = 1;
          mem_addr = imem_addr;
          rv_dly   = $urandom_range(0, 4);
        end else begin
          gnt_dly--;
        end
      end else if (mem_wait) begin
        if (rv_dly == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(mem_addr);
          mem_wait    = 0;
          gnt_dly     = $urandom_range(0, 4);
        end else begin
          rv_dly--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD00000 | 32'(c);
      end

      instr_ready = (c >= 2500) ? 1'b1 : ($urandom_range(0, 2) == 0);
      if (instr_valid && instr_ready) begin
        exp_a = (exp_pc_q.size() > 0) ? exp_pc_q.pop_front() : 32'hFFFFFFFF;
        check("rnd_instr_pc", instr_pc, exp_a);
        check("rnd_instr", instr, mem_word(exp_a));
        n_done++;
        $display("rnd fetch %0d pc=%h instr=%h", n_done, instr_pc, instr);
      end

      tick();
      fault_exp = fault_exp_next;
    end
    clear_inputs();
    check("rnd_outstanding", exp_pc_q.size(), 0);
    check("rnd_some_fetches", (n_done > 50), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
